// File: rtl/des_serial_pkg.sv
// Shared types and constants for the DES result serializer and its future
// UART receiver counterpart.
package des_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int       WORD_WIDTH     = 64;
  localparam int       BITS_PER_BYTE  = 8;
  localparam int       BYTES_PER_WORD = WORD_WIDTH / BITS_PER_BYTE;
  localparam logic     UART_IDLE      = 1'b1;

endpackage

// File: rtl/fifo_uart_transmitter_if.sv
// Read port of the ciphertext FIFO as seen by the UART transmitter.
// The transmitter is the master: it issues pops and consumes data.
interface fifo_uart_transmitter_if
  import des_serial_pkg::*;
#(
  parameter int word_width = WORD_WIDTH
);

  logic                  fifo_empty;
  logic [word_width-1:0] fifo_read_data;
  logic                  fifo_read_enable;

  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    output fifo_read_enable
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    input  fifo_read_enable
  );

endinterface

// File: rtl/fifo_uart_transmitter_baud_tick.sv
// Bit-period timer: counts 0..clocks_per_bit-1 while enabled and emits a
// one-cycle tick on the terminal count. Held at zero while disabled so the
// first bit after enable is a full period.
module baud_tick_generator #(
  parameter int clocks_per_bit = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W    = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(clocks_per_bit - 1);

  logic [CNT_W-1:0] count;

  // Free-running bit-period counter, cleared when idle or on reset.
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == TERMINAL) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/fifo_uart_transmitter.sv
// Pops 64-bit DES result words from the output FIFO and sends them as
// eight 8N1 UART bytes, most significant byte first, LSB first within a byte.
module fifo_uart_transmitter
  import des_serial_pkg::*;
#(
  parameter int clocks_per_bit = 868,
  parameter int word_width     = WORD_WIDTH
) (
  input  logic                           clock,
  input  logic                           reset,
  fifo_uart_transmitter_if.master        fifo,
  output logic                           tx,
  output logic                           busy,
  output logic                           word_done
);

  localparam int BYTES       = word_width / BITS_PER_BYTE;
  localparam int BYTE_CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BIT_CNT_W   = $clog2(BITS_PER_BYTE);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BITS_PER_BYTE - 1);

  tx_state_t               state;
  tx_state_t               state_next;
  logic [word_width-1:0]   shift_reg;
  logic [BITS_PER_BYTE-1:0] cur_byte;
  logic [BYTE_CNT_W-1:0]   byte_count;
  logic [BIT_CNT_W-1:0]    bit_count;
  logic                    baud_enable;
  logic                    tick;
  logic                    last_byte;

  // The byte on the wire is always the top byte; later bytes shift up into it.
  assign cur_byte    = shift_reg[word_width-1 -: BITS_PER_BYTE];
  assign last_byte   = (byte_count == LAST_BYTE);
  assign baud_enable = (state == START) || (state == DATA) || (state == STOP);

  baud_tick_generator #(
    .clocks_per_bit(clocks_per_bit)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .enable(baud_enable),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore output decode; fifo_empty is only looked at in IDLE.
  always_comb begin
    state_next            = state;
    tx                    = UART_IDLE;
    busy                  = 1'b1;
    fifo.fifo_read_enable = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!fifo.fifo_empty) state_next = FETCH;
      end
      FETCH: begin
        fifo.fifo_read_enable = 1'b1;
        state_next            = LATCH;
      end
      LATCH: begin
        state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (tick) state_next = DATA;
      end
      DATA: begin
        tx = cur_byte[bit_count];
        if (tick && (bit_count == LAST_BIT)) state_next = STOP;
      end
      STOP: begin
        if (tick) state_next = last_byte ? IDLE : START;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte and bit position counters; bit_count wraps to 0 after the last bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_count <= '0;
      bit_count  <= '0;
    end else if (state == LATCH) begin
      byte_count <= '0;
      bit_count  <= '0;
    end else if (tick && (state == DATA)) begin
      bit_count <= bit_count + 1'b1;
    end else if (tick && (state == STOP) && !last_byte) begin
      byte_count <= byte_count + 1'b1;
    end
  end

  // Word shift register: loaded from the FIFO one cycle after the pop.
  always_ff @(posedge clock) begin
    if (state == LATCH) begin
      shift_reg <= fifo.fifo_read_data;
    end else if (tick && (state == STOP) && !last_byte) begin
      shift_reg <= shift_reg << BITS_PER_BYTE;
    end
  end

  // One-cycle completion pulse, coincident with the return to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_done <= 1'b0;
    end else begin
      word_done <= tick && (state == STOP) && last_byte;
    end
  end

endmodule

// File: tb/tb_fifo_uart_transmitter.sv
// Bench for fifo_uart_transmitter at clocks_per_bit=4: FIFO model, UART
// receiver model, vector table for the first word, directed corner cases and
// a randomized 16-word scoreboard.
module tb_fifo_uart_transmitter;
  import des_serial_pkg::*;

  localparam int CPB   = 4;
  localparam int WW    = 64;
  localparam int FRAME = 10 * CPB * BYTES_PER_WORD;

  logic clock = 1'b0;
  logic reset;
  logic tx, busy, word_done;

  fifo_uart_transmitter_if #(.word_width(WW)) fifo_bus ();

  fifo_uart_transmitter #(
    .clocks_per_bit(CPB),
    .word_width    (WW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .fifo     (fifo_bus),
    .tx       (tx),
    .busy     (busy),
    .word_done(word_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   off;
    logic tx;
    logic busy;
    logic re;
    logic wd;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  logic [WW-1:0] fifo_q[$];
  logic          toggle_mode = 1'b0;
  logic          toggle_val  = 1'b0;
  int            pops;
  int            wd_count;
  logic          tx_h[$];
  logic          busy_h[$];
  logic          re_h[$];
  logic          wd_h[$];

  logic          rx_active;
  int            rx_cnt;
  logic [7:0]    rx_byte;
  logic [WW-1:0] rx_word;
  int            rx_nbytes;
  logic [WW-1:0] rx_words[$];

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int find_first(input logic q[$], input int from, input logic v);
    for (int i = from; i < q.size(); i++) begin
      if (q[i] === v) return i;
    end
    return -1;
  endfunction

  task automatic clear_obs();
    pops = 0;
    wd_count = 0;
    tx_h.delete();
    busy_h.delete();
    re_h.delete();
    wd_h.delete();
    rx_words.delete();
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_nbytes = 0;
    rx_word = '0;
    rx_byte = '0;
  endtask

  // Mid-bit sampling UART receiver; assembles bytes MSB-first into words.
  task automatic rx_sample(input logic t);
    int k;
    if (!rx_active) begin
      if (t === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        k = rx_cnt / CPB;
        if (k >= 1 && k <= 8) begin
          rx_byte[k-1] = t;
        end else if (k == 9) begin
          chk_int("rx_stop_bit", int'(t), 1);
          rx_word = {rx_word[WW-9:0], rx_byte};
          rx_nbytes++;
          if (rx_nbytes == BYTES_PER_WORD) begin
            rx_words.push_back(rx_word);
            rx_nbytes = 0;
          end
          rx_active = 1'b0;
        end
      end
    end
  endtask

  // One clock: sample at the falling edge, then model the registered FIFO.
  task automatic step();
    logic re_s;
    re_s = fifo_bus.fifo_read_enable;
    tx_h.push_back(tx);
    busy_h.push_back(busy);
    re_h.push_back(re_s);
    wd_h.push_back(word_done);
    if (re_s === 1'b1) pops++;
    if (word_done === 1'b1) wd_count++;
    rx_sample(tx);
    @(posedge clock);
    #1;
    if (re_s === 1'b1) begin
      if (fifo_q.size() > 0) fifo_bus.fifo_read_data = fifo_q.pop_front();
      else fifo_bus.fifo_read_data = '0;
    end
    fifo_bus.fifo_empty = toggle_mode ? toggle_val : (fifo_q.size() == 0);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [WW-1:0] w);
    fifo_q.push_back(w);
    if (!toggle_mode) fifo_bus.fifo_empty = 1'b0;
  endtask

  initial begin
    vec_t          vecs[23];
    logic [WW-1:0] w;
    logic [WW-1:0] exp_words[$];
    int            cnt_a, cnt_b, cnt_c, cnt_d;
    int            idx, end1, start2, pushed;

    vecs[0]  = '{0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{7,   1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{10,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{11,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{38,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{39,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{42,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{43,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{47,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{51,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{55,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{67,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{71,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{287, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{303, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{315, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{322, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{323, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[22] = '{324, 1'b1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    fifo_bus.fifo_empty = 1'b1;
    fifo_bus.fifo_read_data = '0;
    clear_obs();
    @(negedge clock);
    run(2);
    reset = 1'b0;

    // Idle after reset with an empty FIFO.
    clear_obs();
    run(100);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < tx_h.size(); i++) begin
      if (tx_h[i] !== 1'b1) cnt_a++;
      if (re_h[i] !== 1'b0) cnt_b++;
      if (busy_h[i] !== 1'b0) cnt_c++;
      if (wd_h[i] !== 1'b0) cnt_d++;
    end
    chk_int("idle_tx_not_high", cnt_a, 0);
    chk_int("idle_read_enable", cnt_b, 0);
    chk_int("idle_busy", cnt_c, 0);
    chk_int("idle_word_done", cnt_d, 0);

    // Single known word against the timing table.
    clear_obs();
    push(64'h0123456789ABCDEF);
    run(FRAME + 20);
    for (int i = 0; i < 23; i++) begin
      chk_int($sformatf("vec%0d_tx@%0d", i, vecs[i].off), int'(tx_h[vecs[i].off]), int'(vecs[i].tx));
      chk_int($sformatf("vec%0d_busy@%0d", i, vecs[i].off), int'(busy_h[vecs[i].off]), int'(vecs[i].busy));
      chk_int($sformatf("vec%0d_re@%0d", i, vecs[i].off), int'(re_h[vecs[i].off]), int'(vecs[i].re));
      chk_int($sformatf("vec%0d_wd@%0d", i, vecs[i].off), int'(wd_h[vecs[i].off]), int'(vecs[i].wd));
    end
    chk_int("w1_first_fall", find_first(tx_h, 0, 1'b0), 3);
    chk_int("w1_word_done_cycle", find_first(wd_h, 0, 1'b1), 3 + FRAME);
    chk_int("w1_pops", pops, 1);
    chk_int("w1_word_done_count", wd_count, 1);
    chk_int("w1_rx_words", rx_words.size(), 1);
    if (rx_words.size() > 0) chk_word("w1_rx_data", rx_words[0], 64'h0123456789ABCDEF);

    // Two queued words back to back.
    clear_obs();
    push({WW{1'b1}});
    push({WW{1'b0}});
    run(2 * FRAME + 40);
    chk_int("b2b_pops", pops, 2);
    chk_int("b2b_word_done_count", wd_count, 2);
    chk_int("b2b_rx_words", rx_words.size(), 2);
    if (rx_words.size() > 1) begin
      chk_word("b2b_rx_word0", rx_words[0], {WW{1'b1}});
      chk_word("b2b_rx_word1", rx_words[1], {WW{1'b0}});
    end
    end1 = find_first(wd_h, 0, 1'b1);
    chk_int("b2b_word1_end", end1, 3 + FRAME);
    start2 = find_first(tx_h, end1, 1'b0);
    chk_int("b2b_idle_gap", start2 - end1, 3);

    // Reset in the middle of byte 3's data bits.
    clear_obs();
    w = {$urandom, $urandom};
    push(w);
    run(3 + 3 * 10 * CPB + CPB + 10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rx_active = 1'b0;
    rx_nbytes = 0;
    idx = tx_h.size();
    step();
    chk_int("rst_tx_next", int'(tx_h[idx]), 1);
    chk_int("rst_busy_next", int'(busy_h[idx]), 0);
    chk_int("rst_wd_next", int'(wd_h[idx]), 0);
    run(400);
    cnt_a = 0;
    for (int i = idx; i < tx_h.size(); i++) begin
      if (tx_h[i] !== 1'b1) cnt_a++;
    end
    chk_int("rst_tx_low_after", cnt_a, 0);
    chk_int("rst_pops", pops, 1);
    chk_int("rst_word_done_count", wd_count, 0);
    chk_int("rst_rx_words", rx_words.size(), 0);

    // fifo_empty toggling while a word is in flight.
    clear_obs();
    w = {$urandom, $urandom};
    push(w);
    for (int c = 0; c < FRAME + 20; c++) begin
      toggle_mode = (c >= 10) && (c < 300);
      toggle_val = 1'($urandom_range(0, 1));
      step();
    end
    toggle_mode = 1'b0;
    chk_int("tog_pops", pops, 1);
    chk_int("tog_first_fall", find_first(tx_h, 0, 1'b0), 3);
    chk_int("tog_word_done_cycle", find_first(wd_h, 0, 1'b1), 3 + FRAME);
    chk_int("tog_word_done_count", wd_count, 1);
    chk_int("tog_rx_words", rx_words.size(), 1);
    if (rx_words.size() > 0) chk_word("tog_rx_data", rx_words[0], w);

    // Sixteen random words pushed at random times.
    clear_obs();
    pushed = 0;
    for (int c = 0; c < 16 * (FRAME + 4) + 3000 && rx_words.size() < 16; c++) begin
      if (pushed < 16 && ($urandom_range(0, 99) < 3 || c > 1500)) begin
        w = {$urandom, $urandom};
        exp_words.push_back(w);
        push(w);
        pushed++;
      end
      step();
    end
    run(10);
    chk_int("sb_rx_words", rx_words.size(), 16);
    chk_int("sb_pops", pops, 16);
    chk_int("sb_word_done_count", wd_count, 16);
    for (int i = 0; i < 16; i++) begin
      if (i < rx_words.size() && i < exp_words.size())
        chk_word($sformatf("sb_word%0d", i), rx_words[i], exp_words[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
